pc_unit_ras: RTL and testbench

Parametrised program-counter unit for the 16-bit core. Adds four things to the basic PC:
- selectable PC width and reset vector;
- a stall input;
- absolute jump alongside PC-relative branch;
- a hardware return-address stack (RAS) for call/return, with sticky overflow/underflow status.

It sits between the decode/branch logic and instruction memory and drives the fetch address.

---
 rtl/pc_unit_ras_if.sv | 37 +++
 rtl/pc_unit_ras.sv | 95 +++++++++
 tb/tb_pc_unit_ras.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pc_unit_ras_if.sv
// pc_unit_ras_if: request/status bundle between decode/branch logic and the
// program-counter unit.
//   master (decode side): drives stall, branch/jump/call/ret requests,
//                         branch_offset, jump_target; observes pc, pc_plus1,
//                         ras_count and the sticky stack flags.
//   slave  (PC unit)    : the mirror image.
interface pc_unit_ras_if #(
    parameter int unsigned PC_WIDTH  = 10,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

    logic                stall;
    logic                branch_enable;
    logic [PC_WIDTH-1:0] branch_offset;
    logic                jump_enable;
    logic [PC_WIDTH-1:0] jump_target;
    logic                call_enable;
    logic                ret_enable;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_plus1;
    logic [CW-1:0]       ras_count;
    logic                ras_overflow;
    logic                ras_underflow;

    modport master (
        output stall, branch_enable, branch_offset, jump_enable, jump_target,
               call_enable, ret_enable,
        input  pc, pc_plus1, ras_count, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, branch_enable, branch_offset, jump_enable, jump_target,
               call_enable, ret_enable,
        output pc, pc_plus1, ras_count, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_unit_ras.sv
// pc_unit_ras: program counter with stall, PC-relative branch, absolute jump
// and a register-based return-address stack (circular, RAS_DEPTH entries).
//   clk   : rising-edge clock
//   reset : synchronous active-high, overrides everything including stall
//   bus   : pc_unit_ras_if.slave (requests in; pc, pc_plus1, ras_count,
//           ras_overflow, ras_underflow out)
// Next-pc priority: ret > call > jump > branch > pc+1.
module pc_unit_ras #(
    parameter int unsigned         PC_WIDTH     = 10,
    parameter int unsigned         RAS_DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    pc_unit_ras_if.slave    bus
);
    localparam int unsigned  PW   = $clog2(RAS_DEPTH);
    localparam int unsigned  CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]       sp_q, sp_d;      // next free slot; top is sp_q-1
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                push;
    logic [PC_WIDTH-1:0] pc_plus1;
    logic [PC_WIDTH-1:0] top;
    logic [PC_WIDTH-1:0] stack_q [RAS_DEPTH];

    assign pc_plus1 = pc_q + PC_WIDTH'(1);
    assign top      = stack_q[sp_q - PW'(1)];

    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        if (!bus.stall) begin
            if (bus.ret_enable) begin
                if (cnt_q != '0) begin
                    pc_d  = top;
                    sp_d  = sp_q - PW'(1);
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    pc_d  = pc_plus1;
                    unf_d = 1'b1;
                end
            end else if (bus.call_enable) begin
                pc_d = bus.jump_target;
                push = 1'b1;
                // When full, sp_q already points at the oldest entry, so the
                // push overwrites it and the pointer simply keeps wrapping.
                sp_d = sp_q + PW'(1);
                if (cnt_q == FULL) ovf_d = 1'b1;
                else               cnt_d = cnt_q + CW'(1);
            end else if (bus.jump_enable) begin
                pc_d = bus.jump_target;
            end else if (bus.branch_enable) begin
                pc_d = pc_q + bus.branch_offset;   // wraps, so offsets act signed
            end else begin
                pc_d = pc_plus1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_VECTOR;
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry contents need no reset; only the pointer and count define validity.
    always_ff @(posedge clk) begin
        if (!reset && push) stack_q[sp_q] <= pc_plus1;
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus1      = pc_plus1;
    assign bus.ras_count     = cnt_q;
    assign bus.ras_overflow  = ovf_q;
    assign bus.ras_underflow = unf_q;
endmodule

// File: tb/tb_pc_unit_ras.sv
// tb_pc_unit_ras: directed self-checking bench for pc_unit_ras with
// PC_WIDTH=10, RAS_DEPTH=4, RESET_VECTOR=0.
module tb_pc_unit_ras;
    logic clk;
    logic reset;
    int unsigned n_cmp;
    int unsigned n_err;

    pc_unit_ras_if #(.PC_WIDTH(10), .RAS_DEPTH(4)) bus ();

    pc_unit_ras #(
        .PC_WIDTH    (10),
        .RAS_DEPTH   (4),
        .RESET_VECTOR(10'd0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        bus.stall         = 1'b0;
        bus.branch_enable = 1'b0;
        bus.branch_offset = '0;
        bus.jump_enable   = 1'b0;
        bus.jump_target   = '0;
        bus.call_enable   = 1'b0;
        bus.ret_enable    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_jump(input int unsigned t);
        clr(); bus.jump_enable = 1'b1; bus.jump_target = 10'(t); step(); clr();
    endtask

    task automatic do_call(input int unsigned t);
        clr(); bus.call_enable = 1'b1; bus.jump_target = 10'(t); step(); clr();
    endtask

    task automatic do_ret();
        clr(); bus.ret_enable = 1'b1; step(); clr();
    endtask

    task automatic chk_state(input string tag, input int unsigned pc, input int unsigned cnt,
                             input int unsigned ovf, input int unsigned unf);
        check({tag, ".pc"},  bus.pc,            pc);
        check({tag, ".cnt"}, bus.ras_count,     cnt);
        check({tag, ".ovf"}, bus.ras_overflow,  ovf);
        check({tag, ".unf"}, bus.ras_underflow, unf);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clr();

        // Reset wins over stall.
        reset = 1'b1; bus.stall = 1'b1;
        step(); step();
        chk_state("rst", 0, 0, 0, 0);
        reset = 1'b0; clr();
        step(); check("idle1", bus.pc, 1);
        step(); check("idle2", bus.pc, 2);
        step(); check("idle3", bus.pc, 3);
        check("pc_plus1", bus.pc_plus1, 4);

        // Negative branch and wrap.
        do_jump(5); check("jump5", bus.pc, 5);
        bus.branch_enable = 1'b1; bus.branch_offset = 10'h3FE; step(); clr();
        check("branch_m2", bus.pc, 3);
        bus.branch_enable = 1'b1; bus.branch_offset = 10'd7; step(); clr();
        check("branch_p7", bus.pc, 10);
        do_jump(1023); check("jump1023", bus.pc, 1023);
        check("plus1_wrap", bus.pc_plus1, 0);
        step(); check("wrap", bus.pc, 0);

        // Single call/return.
        do_jump(4);
        do_call(100); chk_state("call1", 100, 1, 0, 0);
        step(); check("after_call", bus.pc, 101);
        do_ret(); chk_state("ret1", 5, 0, 0, 0);

        // Nested 3 deep.
        do_jump(200);
        do_call(300); do_call(400); do_call(500);
        chk_state("nest3", 500, 3, 0, 0);
        do_ret(); chk_state("nret1", 401, 2, 0, 0);
        do_ret(); chk_state("nret2", 301, 1, 0, 0);
        do_ret(); chk_state("nret3", 201, 0, 0, 0);

        // Overflow: calls from 10,20,30,40,50.
        do_jump(10);
        do_call(20); do_call(30); do_call(40); do_call(50);
        chk_state("full4", 50, 4, 0, 0);
        do_call(60); chk_state("ovf", 60, 4, 1, 0);
        do_ret(); chk_state("oret1", 51, 3, 1, 0);
        do_ret(); chk_state("oret2", 41, 2, 1, 0);
        do_ret(); chk_state("oret3", 31, 1, 1, 0);
        do_ret(); chk_state("oret4", 21, 0, 1, 0);
        do_ret(); chk_state("unf", 22, 0, 1, 1);

        // Stall discards requests.
        do_call(600); chk_state("pre_stall", 600, 1, 1, 1);
        bus.stall = 1'b1; bus.call_enable = 1'b1; bus.ret_enable = 1'b1;
        bus.branch_enable = 1'b1; bus.branch_offset = 10'd3; bus.jump_target = 10'd900;
        step(); chk_state("stall1", 600, 1, 1, 1);
        step(); chk_state("stall2", 600, 1, 1, 1);
        clr(); step(); chk_state("post_stall", 601, 1, 1, 1);
        do_ret(); chk_state("stall_kept", 23, 0, 1, 1);

        // Clear flags, then ret+call+branch with one entry (value 7).
        reset = 1'b1; step(); reset = 1'b0;
        chk_state("rst2", 0, 0, 0, 0);
        do_jump(6); do_call(50);
        chk_state("one_entry", 50, 1, 0, 0);
        bus.ret_enable = 1'b1; bus.call_enable = 1'b1; bus.jump_target = 10'd90;
        bus.branch_enable = 1'b1; bus.branch_offset = 10'd5;
        step(); clr();
        chk_state("ret_wins", 7, 0, 0, 0);

        // Popped value feeds a call in the very next cycle.
        do_call(70); do_call(80); do_ret();
        check("pop_then", bus.pc, 71);
        do_call(120); chk_state("call_after_pop", 120, 2, 0, 0);

        // Reset mid-call-sequence.
        bus.call_enable = 1'b1; bus.jump_target = 10'd300; reset = 1'b1;
        step(); reset = 1'b0; clr();
        chk_state("rst_mid", 0, 0, 0, 0);
        step(); check("rst_resume", bus.pc, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
